dfe_apb_coeff_regfile: RTL
==========================

Name: dfe_apb_coeff_regfile

Overview:
- Parametrised APB3 slave register file for the DFE filter array; next generation of the single-shot APB config block.
- Holds NUM_BANKS coefficient banks (fractional decimator, IIR 2.4, IIR 5_1, IIR 5_2, ...), each DEPTH words of COEFF_WIDTH.
- Each bank is double-buffered: shadow written over APB, active driven to the filters. Swap is atomic at a frame strobe, so filters never see a half-updated set.
- Adds PREADY wait states, PSLVERR decode errors, sticky W1C status with an interrupt, and per-bank enables.

Parameters:
- ADDR_WIDTH, 10: PADDR width (word addressed); must be >= BANK_W+IDX_W+1.
- PDATA_WIDTH, 32: APB data width; must be >= COEFF_WIDTH and >= 2*NUM_BANKS.
- COEFF_WIDTH, 20: signed coefficient width.
- NUM_BANKS, 4: number of coefficient banks / filter channels.
- DEPTH, 72: coefficients per bank.
- IDX_W, $clog2(DEPTH): localparam.
- BANK_W, max(1,$clog2(NUM_BANKS)): localparam.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  1=write, 0=read
- PADDR  in  ADDR_WIDTH  word address
- PWDATA  in  PDATA_WIDTH  write data
- PRDATA  out  PDATA_WIDTH  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  decode error, valid with PREADY
- frame_stb  in  1  commit point (frame boundary)
- stat_ovf  in  NUM_BANKS  overflow pulses from filters
- stat_udf  in  NUM_BANKS  underflow pulses from filters
- coeff_out  out  NUM_BANKS*DEPTH*COEFF_WIDTH  active coefficients; bank b word i at [(b*DEPTH+i)*COEFF_WIDTH +: COEFF_WIDTH]
- bank_en  out  NUM_BANKS  per-bank enable (CTRL register)
- commit_done  out  NUM_BANKS  1-cycle pulse per committed bank
- irq  out  1  level interrupt

Behaviour:
- One clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset values:
  - Shadow, active, CTRL, PENDING, STATUS and IRQ_EN all 0.
  - PRDATA=0, PSLVERR=0, PREADY=1, commit_done=0, irq=0.
  - rst during a transfer aborts it with no register updated.
- Address map:
  - PADDR[MSB]=0 is coefficient space: bank=PADDR[IDX_W+:BANK_W], idx=PADDR[IDX_W-1:0].
  - PADDR[MSB]=1 is control space, selected by the low bits:
    - 0 CTRL, RW: bank_en.
    - 1 COMMIT: write sets PENDING |= PWDATA[NUM_BANKS-1:0]; read returns PENDING.
    - 2 STATUS, RW1C: ovf at [NUM_BANKS-1:0], udf at [2*NUM_BANKS-1:NUM_BANKS].
    - 3 IRQ_EN, RW: same bit layout as STATUS.
    - 4 VERSION, RO: package constant.
- Decode errors:
  - bank>=NUM_BANKS, idx>=DEPTH, control offset>4, or a write to VERSION.
  - Response: PSLVERR=1 together with PREADY=1 in the access cycle, PRDATA=0, no state change.
- Timing:
  - Writes and control reads: zero wait, complete in the first ACCESS cycle.
  - Coefficient reads: one wait state. PREADY=0 in the first ACCESS cycle; PREADY=1 with data in the second.
  - PREADY=1 whenever there is no access phase.
  - Registers update at the edge ending the ACCESS cycle with PREADY=1.
  - SETUP without a following ACCESS has no effect.
- Width rules:
  - Coefficient write stores PWDATA[COEFF_WIDTH-1:0].
  - Coefficient reads always return the shadow copy, sign-extended to PDATA_WIDTH.
  - Unused bits read as 0.
- Commit:
  - At each edge with frame_stb=1, every bank b with PENDING[b]=1 gets active[b] <= shadow[b] (all DEPTH words), PENDING[b] is cleared, and commit_done[b]=1 for the next cycle.
  - COMMIT write in the same cycle as frame_stb: the strobe uses the old PENDING; the new bits commit on the next strobe.
  - Shadow write in the same cycle as frame_stb: the copy takes the old shadow value.
  - Writing shadow while pending is allowed; the last value before the strobe is committed.
  - Committing is independent of bank_en.
- Status:
  - A stat_* pulse sets its sticky bit.
  - Writing 1 clears a bit; set and clear in the same cycle leaves the bit set.
  - irq is registered: irq = |(STATUS & IRQ_EN), one cycle after the bit change.

Decomposition:
- Package dfe_apb_pkg holds:
  - control offsets (CTRL, COMMIT, STATUS, IRQ_EN, VERSION);
  - the VERSION constant;
  - an apb_state_e enum (IDLE, ACCESS, WAIT).
- Sub-module dfe_coeff_bank: one bank's shadow+active storage, word write port, registered read port and commit copy. Instantiated NUM_BANKS times.
- The top level holds the APB FSM, decode, control/status registers and irq.

Test Plan:
- Reset then read: read every bank idx 0 and DEPTH-1, plus STATUS -> all 0, PSLVERR=0. Coefficient reads show exactly one PREADY=0 cycle.
- Shadow/commit:
  - Write bank1 idx5 = 0xFFFFF, read back -> PRDATA=0xFFFFFFFF, coeff_out bank1 idx5 still 0.
  - COMMIT=0x2, then frame_stb -> coeff_out bank1 idx5 = 0xFFFFF, commit_done=0x2 for 1 cycle, PENDING reads 0.
- Simultaneous events:
  - COMMIT=0x1 in the same cycle as frame_stb -> no copy.
  - Next frame_stb -> bank0 copied.
  - Shadow write coinciding with a commit -> active gets the old value.
- Errors:
  - Read idx 72 with DEPTH=72 -> PSLVERR=1, PRDATA=0.
  - Write VERSION -> PSLVERR=1 and VERSION unchanged.
  - Control offset 7 -> PSLVERR=1.
- Status/irq:
  - IRQ_EN=0x10, pulse stat_udf[0] -> STATUS=0x10, irq=1 a cycle later.
  - Write STATUS=0x10 coinciding with a new pulse -> bit stays 1.
  - Clean W1C -> irq=0.
- Reset mid-transfer: assert rst during the coefficient-read wait state -> PREADY=1, PRDATA=0, registers cleared, next transfer completes normally.

Source files
------------

// File: rtl/dfe_apb_pkg.sv
// DFE coefficient register file: shared constants and types.
// Control-space offsets, version word and APB FSM states.
package dfe_apb_pkg;

  localparam int OFF_CTRL    = 0;
  localparam int OFF_COMMIT  = 1;
  localparam int OFF_STATUS  = 2;
  localparam int OFF_IRQ_EN  = 3;
  localparam int OFF_VERSION = 4;

  localparam logic [31:0] VERSION = 32'h0002_0100;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT
  } apb_state_e;

endpackage

// File: rtl/dfe_coeff_bank.sv
// One coefficient bank: APB-side shadow copy and filter-side active copy.
// Registered read of the shadow; whole-bank copy on commit.
module dfe_coeff_bank
  import dfe_apb_pkg::*;
#(
  parameter int COEFF_WIDTH = 20,
  parameter int DEPTH       = 72,
  parameter int IDX_W       = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_we,
  input  logic [IDX_W-1:0]             i_widx,
  input  logic [COEFF_WIDTH-1:0]       i_wdata,
  input  logic                         i_rd_en,
  input  logic [IDX_W-1:0]             i_ridx,
  input  logic                         i_commit,
  output logic [COEFF_WIDTH-1:0]       o_rdata,
  output logic [DEPTH*COEFF_WIDTH-1:0] o_active
);

  logic [COEFF_WIDTH-1:0] r_shadow [DEPTH];
  logic [COEFF_WIDTH-1:0] r_active [DEPTH];
  logic [COEFF_WIDTH-1:0] r_rdata;

  // Copy reads the pre-edge shadow, so a same-cycle write lands next commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_rdata <= '0;
    end else begin
      if (i_we) r_shadow[i_widx] <= i_wdata;
      if (i_commit) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_active[i] <= r_shadow[i];
        end
      end
      if (i_rd_en) r_rdata <= r_shadow[i_ridx];
    end
  end

  assign o_rdata = r_rdata;

  for (genvar g = 0; g < DEPTH; g++) begin : g_act
    assign o_active[g*COEFF_WIDTH +: COEFF_WIDTH] = r_active[g];
  end

endmodule

// File: rtl/dfe_apb_coeff_regfile.sv
// APB3 register file for DFE filter coefficients with framed commit,
// sticky W1C status, interrupt and per-bank enables.
module dfe_apb_coeff_regfile
  import dfe_apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int PDATA_WIDTH = 32,
  parameter int COEFF_WIDTH = 20,
  parameter int NUM_BANKS   = 4,
  parameter int DEPTH       = 72
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [ADDR_WIDTH-1:0]  PADDR,
  input  logic [PDATA_WIDTH-1:0] PWDATA,
  output logic [PDATA_WIDTH-1:0] PRDATA,
  output logic                   PREADY,
  output logic                   PSLVERR,
  input  logic                   frame_stb,
  input  logic [NUM_BANKS-1:0]   stat_ovf,
  input  logic [NUM_BANKS-1:0]   stat_udf,
  output logic [NUM_BANKS*DEPTH*COEFF_WIDTH-1:0] coeff_out,
  output logic [NUM_BANKS-1:0]   bank_en,
  output logic [NUM_BANKS-1:0]   commit_done,
  output logic                   irq
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int SW     = 2 * NUM_BANKS;
  localparam int OW     = ADDR_WIDTH - 1;
  localparam int BW     = DEPTH * COEFF_WIDTH;

  localparam logic [OW-1:0] A_CTRL = OW'(OFF_CTRL);
  localparam logic [OW-1:0] A_CMT  = OW'(OFF_COMMIT);
  localparam logic [OW-1:0] A_STAT = OW'(OFF_STATUS);
  localparam logic [OW-1:0] A_IEN  = OW'(OFF_IRQ_EN);
  localparam logic [OW-1:0] A_VER  = OW'(OFF_VERSION);
  localparam logic [BANK_W:0] NB_L = (BANK_W+1)'(NUM_BANKS);
  localparam logic [IDX_W:0]  DP_L = (IDX_W+1)'(DEPTH);

  apb_state_e                  r_state;
  logic                        r_pready;
  logic                        r_pslverr;
  logic [PDATA_WIDTH-1:0]      r_prdata;
  logic [NUM_BANKS-1:0]        r_ctrl;
  logic [NUM_BANKS-1:0]        r_pending;
  logic [SW-1:0]               r_status;
  logic [SW-1:0]               r_irq_en;
  logic [NUM_BANKS-1:0]        r_commit_done;
  logic                        r_irq;

  logic                        w_ctl;
  logic [OW-1:0]               w_off;
  logic [OW-1:0]               w_hi;
  logic [IDX_W-1:0]            w_idx;
  logic [BANK_W-1:0]           w_bank;
  logic                        w_cerr;
  logic                        w_rerr;
  logic                        w_err;
  logic                        w_setup;
  logic                        w_acc;
  logic                        w_wr;
  logic                        w_cwr;
  logic                        w_rd_en;
  logic [NUM_BANKS-1:0]        w_commit;
  logic [SW-1:0]               w_clr;
  logic [PDATA_WIDTH-1:0]      w_ctl_rd;
  logic [COEFF_WIDTH-1:0]      w_rdata [NUM_BANKS];
  logic                        w_unused;

  assign w_ctl  = PADDR[ADDR_WIDTH-1];
  assign w_off  = PADDR[OW-1:0];
  assign w_hi   = w_off >> (BANK_W + IDX_W);
  assign w_idx  = PADDR[IDX_W-1:0];
  assign w_bank = PADDR[IDX_W +: BANK_W];

  assign w_cerr = (w_hi != '0)
                | ({1'b0, w_bank} >= NB_L)
                | ({1'b0, w_idx} >= DP_L);
  assign w_rerr = (w_off > A_VER)
                | (PWRITE & (w_off == A_VER));
  assign w_err  = w_ctl ? w_rerr : w_cerr;

  assign w_setup = PSEL & ~PENABLE;
  assign w_acc   = PSEL & PENABLE;
  assign w_wr    = (r_state == ACCESS) & w_acc
                 & PWRITE & ~r_pslverr;
  assign w_cwr   = w_wr & ~w_ctl;
  assign w_rd_en = (r_state == IDLE) & w_setup
                 & ~w_ctl & ~PWRITE;

  assign w_commit = frame_stb ? r_pending : '0;
  assign w_clr    = (w_wr & w_ctl & (w_off == A_STAT))
                  ? PWDATA[SW-1:0] : '0;
  assign w_unused = ^PWDATA;

  always_comb begin
    w_ctl_rd = '0;
    case (w_off)
      A_CTRL:  w_ctl_rd = PDATA_WIDTH'(r_ctrl);
      A_CMT:   w_ctl_rd = PDATA_WIDTH'(r_pending);
      A_STAT:  w_ctl_rd = PDATA_WIDTH'(r_status);
      A_IEN:   w_ctl_rd = PDATA_WIDTH'(r_irq_en);
      A_VER:   w_ctl_rd = PDATA_WIDTH'(VERSION);
      default: w_ctl_rd = '0;
    endcase
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    dfe_coeff_bank #(
      .COEFF_WIDTH(COEFF_WIDTH),
      .DEPTH      (DEPTH),
      .IDX_W      (IDX_W)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_cwr & (w_bank == BANK_W'(b))),
      .i_widx  (w_idx),
      .i_wdata (PWDATA[COEFF_WIDTH-1:0]),
      .i_rd_en (w_rd_en),
      .i_ridx  (w_idx),
      .i_commit(w_commit[b]),
      .o_rdata (w_rdata[b]),
      .o_active(coeff_out[b*BW +: BW])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_pready      <= 1'b1;
      r_pslverr     <= 1'b0;
      r_prdata      <= '0;
      r_ctrl        <= '0;
      r_pending     <= '0;
      r_status      <= '0;
      r_irq_en      <= '0;
      r_commit_done <= '0;
      r_irq         <= 1'b0;
    end else begin
      r_commit_done <= w_commit;
      r_irq         <= |(r_status & r_irq_en);
      r_status      <= (r_status & ~w_clr)
                     | {stat_udf, stat_ovf};
      r_pending     <= (r_pending & ~w_commit)
                     | ((w_wr & w_ctl & (w_off == A_CMT))
                        ? PWDATA[NUM_BANKS-1:0] : '0);
      if (w_wr & w_ctl & (w_off == A_CTRL))
        r_ctrl <= PWDATA[NUM_BANKS-1:0];
      if (w_wr & w_ctl & (w_off == A_IEN))
        r_irq_en <= PWDATA[SW-1:0];
      case (r_state)
        IDLE: begin
          if (w_setup) begin
            r_pslverr <= w_err;
            if (!w_ctl && !PWRITE && !w_err) begin
              r_state  <= WAIT;
              r_pready <= 1'b0;
              r_prdata <= '0;
            end else begin
              r_state  <= ACCESS;
              r_pready <= 1'b1;
              r_prdata <= (!PWRITE && w_ctl && !w_err)
                        ? w_ctl_rd : '0;
            end
          end
        end
        WAIT: begin
          r_pready <= 1'b1;
          if (w_acc) begin
            r_state  <= ACCESS;
            r_prdata <= PDATA_WIDTH'($signed(w_rdata[w_bank]));
          end else begin
            r_state <= IDLE;
          end
        end
        ACCESS: begin
          r_state   <= IDLE;
          r_pready  <= 1'b1;
          r_pslverr <= 1'b0;
          r_prdata  <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign PREADY      = r_pready;
  assign PSLVERR     = r_pslverr;
  assign PRDATA      = r_prdata;
  assign bank_en     = r_ctrl;
  assign commit_done = r_commit_done;
  assign irq         = r_irq;

endmodule
